// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-side handshake and HI/LO result bundle for the
// multiply/divide sequencer. The EX stage is the master: it presents ops
// and cancels them. The sequencer is the slave: it reports busy/done and
// drives the architectural HI/LO.
interface muldiv_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op_valid, op, src_a, src_b, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  op_valid, op, src_a, src_b, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multicycle multiply/divide sequencer owning HI/LO.
//   MULT/MULTU run through a MUL_LAT-stage multiplier pipeline.
//   DIV/DIVU run a 32-iteration radix-2 restoring divider followed by a
//   FIX cycle that applies signs and the divide-by-zero result.
//   MTHI/MTLO write HI/LO directly at the accept edge without going busy.
// Optional feature macro: HILO_FWD_EN -- when defined, hi/lo show the value
// being committed in the same cycle (combinational bypass of the registers).
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input logic         clk,
    input logic         rst,
    muldiv_ctrl_if.slave bus
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
    localparam logic [4:0] DIV_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        busy_reg;
    logic [4:0]  cnt_reg, cnt_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic        done_int;

    // Accept and op decode
    logic accept;
    logic is_mul;
    logic is_div;

    assign accept = bus.op_valid && !busy_reg && !bus.cancel;
    assign is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);

    // ------------------------------------------------------------------
    // Multiplier: operands extended to 33 bits (sign for MULT, zero for
    // MULTU); the 64-bit two's-complement product of the extended values
    // is exactly the architectural {hi,lo}.
    // ------------------------------------------------------------------
    logic               mul_signed;
    logic signed [32:0] mul_a33, mul_b33;
    logic signed [63:0] mul_a_ext, mul_b_ext;
    logic        [63:0] mul_prod;
    logic        [63:0] mul_pipe [MUL_LAT];

    assign mul_signed = (bus.op == OP_MULT);
    assign mul_a33    = {mul_signed & bus.src_a[31], bus.src_a};
    assign mul_b33    = {mul_signed & bus.src_b[31], bus.src_b};
    assign mul_a_ext  = {{31{mul_a33[32]}}, mul_a33};
    assign mul_b_ext  = {{31{mul_b33[32]}}, mul_b33};
    assign mul_prod   = mul_a_ext * mul_b_ext;

    // Product pipeline: stage 0 captures at the accept edge, later stages shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_pipe[i] <= '0;
            end
        end else begin
            if (accept && is_mul) begin
                mul_pipe[0] <= mul_prod;
            end
            for (int i = 1; i < MUL_LAT; i++) begin
                mul_pipe[i] <= mul_pipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Divider: magnitudes and result signs latched at accept; the dividend
    // register doubles as the quotient shift register.
    // ------------------------------------------------------------------
    logic        div_signed;
    logic [31:0] div_a_abs, div_b_abs;
    logic [31:0] div_quo_reg;
    logic [31:0] div_b_reg;
    logic [31:0] div_rem_reg;
    logic        div_qsign_reg;
    logic        div_rsign_reg;
    logic        div_zero_reg;
    logic [31:0] div_src_a_reg;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] fix_hi, fix_lo;

    assign div_signed = (bus.op == OP_DIV);
    assign div_a_abs  = (div_signed && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
    assign div_b_abs  = (div_signed && bus.src_b[31]) ? (32'd0 - bus.src_b) : bus.src_b;

    // One restoring step: shift next dividend bit into the partial remainder
    // and try to subtract the divisor; a borrow in bit 32 means "restore".
    assign div_shift = {div_rem_reg, div_quo_reg[31]};
    assign div_diff  = div_shift - {1'b0, div_b_reg};

    // Divider datapath: load at accept, one quotient bit per DIV cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_quo_reg   <= '0;
            div_b_reg     <= '0;
            div_rem_reg   <= '0;
            div_qsign_reg <= 1'b0;
            div_rsign_reg <= 1'b0;
            div_zero_reg  <= 1'b0;
            div_src_a_reg <= '0;
        end else if (accept && is_div) begin
            div_quo_reg   <= div_a_abs;
            div_b_reg     <= div_b_abs;
            div_rem_reg   <= '0;
            div_qsign_reg <= div_signed & (bus.src_a[31] ^ bus.src_b[31]);
            div_rsign_reg <= div_signed & bus.src_a[31];
            div_zero_reg  <= (bus.src_b == 32'd0);
            div_src_a_reg <= bus.src_a;
        end else if (state_reg == DIV) begin
            if (!div_diff[32]) begin
                div_rem_reg <= div_diff[31:0];
                div_quo_reg <= {div_quo_reg[30:0], 1'b1};
            end else begin
                div_rem_reg <= div_shift[31:0];
                div_quo_reg <= {div_quo_reg[30:0], 1'b0};
            end
        end
    end

    // Sign fix-up; 0x80000000/-1 falls out naturally (magnitude 2^31, no
    // negation), divide-by-zero overrides with all-ones / original dividend.
    assign fix_lo = div_zero_reg ? 32'hFFFF_FFFF
                  : (div_qsign_reg ? (32'd0 - div_quo_reg) : div_quo_reg);
    assign fix_hi = div_zero_reg ? div_src_a_reg
                  : (div_rsign_reg ? (32'd0 - div_rem_reg) : div_rem_reg);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // Next state, counter, HI/LO write data and done pulse
    always_comb begin
        state_next = state_reg;
        cnt_next   = 5'd0;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_int   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: state_next = MUL;
                        OP_DIV,  OP_DIVU:  state_next = DIV;
                        OP_MTHI:           hi_next    = bus.src_a;
                        OP_MTLO:           lo_next    = bus.src_a;
                        default:           ;
                    endcase
                end
            end
            MUL: begin
                if (cnt_reg == MUL_LAST) begin
                    done_int   = 1'b1;
                    state_next = IDLE;
                    hi_next    = mul_pipe[MUL_LAT-1][63:32];
                    lo_next    = mul_pipe[MUL_LAT-1][31:0];
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            DIV: begin
                if (cnt_reg == DIV_LAST) begin
                    state_next = FIX;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            FIX: begin
                done_int   = 1'b1;
                state_next = IDLE;
                hi_next    = fix_hi;
                lo_next    = fix_lo;
            end
            default: state_next = IDLE;
        endcase

        // A flush during any busy cycle drops the op without committing
        if (bus.cancel && (state_reg != IDLE)) begin
            state_next = IDLE;
            cnt_next   = 5'd0;
            hi_next    = hi_reg;
            lo_next    = lo_reg;
            done_int   = 1'b0;
        end
    end

    // State, counter, busy flag and architectural HI/LO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
            busy_reg  <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= (state_next != IDLE);
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_int;

`ifdef HILO_FWD_EN
    assign bus.hi = hi_next;
    assign bus.lo = lo_next;
`else
    assign bus.hi = hi_reg;
    assign bus.lo = lo_reg;
`endif

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multicycle multiply/divide sequencer that owns the architectural HI/LO registers. It sits beside the EX stage and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decoded HI/LO write class. It runs a pipelined multiplier or a radix-2 restoring divider, stalls the pipeline through `busy`, and commits results to HI/LO. Exceptions reported by later stages abort an in-flight operation through `cancel`.

## Interface
- `MUL_LAT`, 2, multiplier latency in cycles, legal 1..4.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  EX presents a HI/LO-writing op this cycle.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 ignored (no effect).
- `src_a`  in  32  GPR[rs]: multiplicand, dividend, or MTHI/MTLO data.
- `src_b`  in  32  GPR[rt]: multiplier or divisor.
- `cancel`  in  1  flush; aborts the in-flight op and blocks acceptance this cycle.
- `busy`  out  1  registered; high while a MUL/DIV is in flight; upstream stalls.
- `done`  out  1  one-cycle pulse in the cycle whose closing edge writes HI/LO from MUL/DIV.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- Accept condition: `op_valid && !busy && !cancel` (cycle t). `op_valid` while busy is ignored; upstream holds the op.
- States: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on accepted op 0/1.
  - IDLE -> DIV on accepted op 2/3.
  - MTHI/MTLO write `hi`/`lo` = `src_a` at the accept edge. The state stays IDLE; `busy` is never raised.
- MUL:
  - Operands are extended to 33 bits: sign-extended for MULT, zero-extended for MULTU.
  - The product passes through MUL_LAT register stages; {hi,lo} takes product[63:0].
- DIV:
  - At accept, register |a|, |b|, quotient sign (a[31]^b[31]) and remainder sign (a[31]). Signed ops only; unsigned ops have positive signs.
  - 32 iterations, one quotient bit per cycle, driven by a 5-bit counter 0..31.
  - DIV -> FIX after iteration 31. FIX applies the signs and writes lo=quotient, hi=remainder.
- Divide by zero: same latency; lo=32'hFFFFFFFF, hi=`src_a` as issued. Applies to both signed and unsigned.
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0.
- Cancel:
  - In any busy cycle, including the `done` cycle, the state returns to IDLE at the next edge.
  - HI/LO are unchanged and `done` is suppressed in that cycle.
- Reset (any time): state IDLE, `hi`=`lo`=0, `busy`=0, `done`=0, counter 0. In-flight work is discarded.

## Timing
- MTHI/MTLO: write at the end of cycle t; new value visible on `hi`/`lo` from t+1.
- MUL/MULTU:
  - `busy` high in cycles t+1..t+MUL_LAT.
  - `done` in cycle t+MUL_LAT; result visible at t+MUL_LAT+1.
- DIV/DIVU:
  - `busy` high in cycles t+1..t+33 (32 DIV cycles, then FIX).
  - `done` in t+33; result visible at t+34.
- `busy` falls in the cycle after `done`. The earliest back-to-back accept is that cycle.
- The issuing instruction proceeds past EX at cycle t. Later instructions stall while `busy`=1.

## Configuration
- `HILO_FWD_EN` defined:
  - `hi`/`lo` are combinationally bypassed, so the value being committed appears in the same cycle.
  - Bypass cycles: the MTHI/MTLO accept cycle, and the `done` cycle unless `cancel` is high.
- `HILO_FWD_EN` undefined: `hi`/`lo` are pure register outputs; new values appear one cycle later, as in Timing.

## Test plan
- Reset during a DIV at iteration 10:
  - Expected: `busy`=0, `hi`=`lo`=0 immediately.
  - Release reset, then MTLO 0x1234: `lo`=0x1234 at t+1; `busy` never rises.
- MULT 0xFFFFFFFE × 3 (MUL_LAT=2):
  - `busy` high t+1..t+2, `done` at t+2.
  - At t+3: hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Repeat as MULTU: hi=0x00000002, lo=0xFFFFFFFA.
- DIV signed:
  - -7/2: at t+34, lo=0xFFFFFFFD, hi=0xFFFFFFFF; `busy` exactly 33 cycles.
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU 100/0: lo=0xFFFFFFFF, hi=100 at t+34.
- Cancel in the `done` cycle of a DIV:
  - HI/LO keep their prior values; no `done` pulse; `busy`=0 next cycle.
  - Cancel with `op_valid` in IDLE: op not accepted.
- `op_valid` MTHI while `busy`: ignored.
- With `HILO_FWD_EN`: MTHI 0xCAFE shows `hi`=0xCAFE in cycle t. Without it, `hi`=0xCAFE only from t+1.
